wb_regfile: RTL and testbench

- Write-back stage plus architectural register file for the 5-stage MIPS pipeline.
- Sits directly downstream of the MEM/WB pipeline register and consumes its ReadData, AluResult and destination-register (Mux) outputs, plus the WB control bits.
- Selects the write-back value, commits it to a 32x32 register file, and serves the two decode-stage read ports with same-cycle write-through bypass.
- Keeps a committed-write counter for debug and bench checking.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/wb_mux.sv | 17 +
 rtl/wb_regfile.sv | 89 ++++++++
 tb/tb_wb_regfile.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and WB control bundle
//   DATA_W   : register/data width
//   ADDR_W   : register index width
//   NREGS    : architectural register count (2**ADDR_W)
//   REG_ZERO : index of the hardwired-zero register
//   wb_ctrl_t: write-back control bits carried down the pipeline registers
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_mux.sv
// rtl/wb_mux.sv - 2:1 write-back / forwarding value selector
//   sel : 1 selects in1, 0 selects in0
//   in0 : value chosen when sel=0 (ALU result in the WB stage)
//   in1 : value chosen when sel=1 (load data in the WB stage)
//   y   : selected value, combinational
module wb_mux #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 32x32 register file with write-through bypass
//   Clk       : pipeline clock, rising edge
//   Rst       : asynchronous active-high reset, clears registers and WbCount
//   RegWrite  : commit WriteData to WriteReg on this edge
//   MemtoReg  : 1 = write ReadData, 0 = write AluResult
//   ReadData  : load data from MEM/WB
//   AluResult : ALU result from MEM/WB
//   WriteReg  : destination register index
//   ReadReg1/2: decode-stage read indices
//   ReadData1/2: combinational read data, bypassed from WriteData on a match
//   WriteData : selected write-back value, also used by EX forwarding
//   WbCount   : number of committed register writes, wraps
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int NREGS  = mips_pkg::NREGS
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData,
    output logic [31:0]       WbCount
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    wb_ctrl_t          ctrl;
    logic              commit;
    logic [DATA_W-1:0] regs [NREGS];
    logic [31:0]       wb_count_q;

    assign ctrl.RegWrite = RegWrite;
    assign ctrl.MemtoReg = MemtoReg;

    wb_mux #(.W(DATA_W)) u_wb_mux (
        .sel (ctrl.MemtoReg),
        .in0 (AluResult),
        .in1 (ReadData),
        .y   (WriteData)
    );

    // Writes to r0 are dropped entirely, so r0 stays at its reset value of 0.
    assign commit = ctrl.RegWrite && (WriteReg != ZERO_IDX);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (commit) begin
            regs[WriteReg] <= WriteData;
            wb_count_q     <= wb_count_q + 32'd1;
        end
    end

    // Write-first reads: a same-cycle write to the read index is forwarded,
    // which hides the WB->ID hazard without a split-phase register file.
    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (ReadReg1 == ZERO_IDX) begin
            ReadData1 = '0;
        end else if (commit && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (ReadReg2 == ZERO_IDX) begin
            ReadData2 = '0;
        end else if (commit && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end
    end

    assign WbCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

    logic        Clk;
    logic        Rst;
    logic        RegWrite;
    logic        MemtoReg;
    logic [31:0] ReadData;
    logic [31:0] AluResult;
    logic [4:0]  WriteReg;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData;
    logic [31:0] WbCount;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] cnt_q [$];

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e_wd;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    wb_regfile dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .ReadData  (ReadData),
        .AluResult (AluResult),
        .WriteReg  (WriteReg),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .WriteData (WriteData),
        .WbCount   (WbCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite  = rw;
        MemtoReg  = m2r;
        ReadData  = rd;
        AluResult = alu;
        WriteReg  = wr;
        ReadReg1  = r1;
        ReadReg2  = r2;
    endtask

    initial begin
        //            rw    m2r   rd            alu           wr     r1     r2     wd            rd1           rd2           cnt
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        32'h0000_00A5, 5'd8,  5'd8,  5'd0,  32'h0000_00A5, 32'h0000_00A5, 32'h0,        32'd1};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd8,  5'd8,  5'd8,  32'h0,        32'h0000_00A5, 32'h0000_00A5, 32'd1};
        tbl[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8,  5'd0,  5'd8,  32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 32'd2};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd8,  5'd0,  32'h0,        32'hDEAD_BEEF, 32'h0,        32'd2};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0,        32'h0,        32'd2};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd8,  32'h0,        32'h0,        32'hDEAD_BEEF, 32'd2};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,        32'h1111_1111, 5'd9,  5'd9,  5'd9,  32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'd3};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        32'h2222_2222, 5'd9,  5'd9,  5'd9,  32'h2222_2222, 32'h1111_1111, 32'h1111_1111, 32'd3};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        32'h2222_2222, 5'd9,  5'd9,  5'd9,  32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'd4};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd9,  5'd9,  5'd9,  32'h0,        32'h2222_2222, 32'h2222_2222, 32'd4};
        tbl[10] = '{1'b1, 1'b0, 32'h0,        32'h0000_0033, 5'd3,  5'd3,  5'd4,  32'h0000_0033, 32'h0000_0033, 32'h0,        32'd5};
        tbl[11] = '{1'b1, 1'b0, 32'h0,        32'h0000_0044, 5'd4,  5'd3,  5'd4,  32'h0000_0044, 32'h0000_0033, 32'h0000_0044, 32'd6};
        tbl[12] = '{1'b0, 1'b1, 32'hCAFE_F00D, 32'h0,        5'd3,  5'd3,  5'd4,  32'hCAFE_F00D, 32'h0000_0033, 32'h0000_0044, 32'd6};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd8,  5'd9,  32'h0,        32'hDEAD_BEEF, 32'h2222_2222, 32'd6};
        tbl[14] = '{1'b1, 1'b1, 32'h8000_0001, 32'h0,        5'd31, 5'd31, 5'd30, 32'h8000_0001, 32'h8000_0001, 32'h0,        32'd7};
        tbl[15] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd31, 5'd30, 32'h0,        32'h8000_0001, 32'h0,        32'd7};

        Rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h5555_5555, 5'd5, 5'd5, 5'd6);
        #2;
        check("reset_cnt", WbCount, 32'h0);
        RegWrite = 1'b0;
        #1;
        check("reset_rd1", ReadData1, 32'h0);
        check("reset_rd2", ReadData2, 32'h0);
        @(posedge Clk); #1;
        check("reset_hold_cnt", WbCount, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge Clk);
            drive(tbl[i].rw, tbl[i].m2r, tbl[i].rd, tbl[i].alu, tbl[i].wr, tbl[i].r1, tbl[i].r2);
            #1;
            check($sformatf("v%0d_wd", i), WriteData, tbl[i].e_wd);
            check($sformatf("v%0d_rd1", i), ReadData1, tbl[i].e_rd1);
            check($sformatf("v%0d_rd2", i), ReadData2, tbl[i].e_rd2);
            cnt_q.push_back(tbl[i].e_cnt);
            @(posedge Clk); #1;
            if (cnt_q.size() == 0) begin
                check($sformatf("v%0d_sb_empty", i), 32'h1, 32'h0);
            end else begin
                check($sformatf("v%0d_cnt", i), WbCount, cnt_q.pop_front());
            end
        end

        // Fill r1..r31 with distinct values.
        for (int r = 1; r < 32; r++) begin
            @(negedge Clk);
            drive(1'b1, 1'b0, 32'h0, 32'h100 + 32'(r), 5'(r), 5'd0, 5'd0);
        end
        @(negedge Clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd31);
        #1;
        check("fill_rd1", ReadData1, 32'h0000_0111);
        check("fill_rd2", ReadData2, 32'h0000_011F);
        check("fill_cnt", WbCount, 32'd38);

        // Reset mid-cycle with a write pending to r5.
        @(negedge Clk);
        drive(1'b1, 1'b0, 32'h0, 32'hDEAD_0005, 5'd5, 5'd17, 5'd31);
        #2;
        Rst = 1'b1;
        #1;
        check("midrst_rd1", ReadData1, 32'h0);
        check("midrst_rd2", ReadData2, 32'h0);
        check("midrst_cnt", WbCount, 32'h0);
        @(posedge Clk); #1;
        RegWrite = 1'b0;
        ReadReg1 = 5'd5;
        #1;
        check("midrst_r5", ReadData1, 32'h0);
        check("midrst_cnt_edge", WbCount, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0066, 5'd6, 5'd6, 5'd0);
        @(posedge Clk); #1;
        check("post_rst_cnt", WbCount, 32'd1);
        RegWrite = 1'b0;
        #1;
        check("post_rst_r6", ReadData1, 32'h0000_0066);

        // Counter wrap via back-door preload.
        @(negedge Clk);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        check("preload_cnt", WbCount, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd7, 5'd7, 5'd0);
        @(posedge Clk); #1;
        check("wrap_cnt", WbCount, 32'h0);
        @(negedge Clk);
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd0, 5'd7, 5'd0);
        @(posedge Clk); #1;
        check("wrap_r0_cnt", WbCount, 32'h0);
        RegWrite = 1'b0;
        #1;
        check("wrap_r7", ReadData1, 32'h0000_0077);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
